number_grid_controller: RTL and testbench
=========================================

NUMBER_GRID_CONTROLLER -- requirements
Module: number_grid_controller

Interface
REQ-001 Parameters SHALL be: ROWS, default 3, tile rows; COLS, default 4, tile columns; X0, default 150, grid left edge; Y0, default 150, grid top edge; DX, default 50, column pitch; DY, default 50, row pitch; TILE_W, default 16, tile width; TILE_H, default 32, tile height; BLINK_FRAMES, default 30, blink duration in frames; LFSR_SEED, default 16'hACE1.
REQ-002 Parameter legality SHALL be: DX >= TILE_W; DY >= TILE_H; ROWS*COLS between 1 and 16; all tiles inside 640x480.
REQ-003 Ports SHALL be: clk in 1, system clock; reset in 1, asynchronous active-high reset; pixelX in 11, VGA column; pixelY in 11, VGA row; startOfFrame in 1, one-cycle pulse per frame; newRound in 1, one-cycle pulse that re-randomises the grid; singleHit in 1, collision pulse with the currently drawn tile pixel.
REQ-004 Further ports SHALL be: drawingRequest out 1, tile pixel visible; digitValue out 4, digit of the drawn tile; offsetX out 5, pixelX minus tile left; offsetY out 6, pixelY minus tile top; hitValid out 1, one-cycle hit pulse; hitIndex out 4, hit tile index; hitValue out 4, hit tile digit; allCleared out 1, every tile cleared; loading out 1, controller in LOAD.

Function
REQ-005 The tile index SHALL be k = r*COLS + c; tile top-left SHALL be (X0 + c*DX, Y0 + r*DY).
REQ-006 The controller FSM SHALL have states IDLE, LOAD and PLAY.
REQ-007 IDLE SHALL go to LOAD on newRound.
REQ-008 LOAD SHALL write one tile per cycle, index 0 upward, setting each to SHOWN; LOAD SHALL last exactly ROWS*COLS cycles and then enter PLAY.
REQ-009 newRound in any state, including mid-LOAD and PLAY, SHALL restart LOAD at index 0 on the next cycle.
REQ-010 The LFSR SHALL be 16 bits, Fibonacci, taps 16,14,13,11, stepping every cycle from reset.
REQ-011 A tile loaded from LFSR nibble n=lfsr[3:0] SHALL take value n-10 when n>=10, else n, so the result is always 0..9.
REQ-012 Each tile SHALL hold a state: EMPTY, SHOWN, BLINK or CLEARED.
REQ-013 Hit detection, in PLAY only, SHALL trigger when singleHit is asserted while the registered drawingRequest is 1 for tile k and tile k is SHOWN.
REQ-014 On a hit, tile k SHALL go to BLINK, load its blink counter with BLINK_FRAMES, and pulse hitValid one cycle later with hitIndex=k and hitValue set to its digit.
REQ-015 singleHit on a BLINK, CLEARED or EMPTY tile, on no tile, or outside PLAY SHALL be ignored, with no hitValid.
REQ-016 Each BLINK tile's counter SHALL decrement on startOfFrame; at 0 the tile SHALL go to CLEARED.
REQ-017 A BLINK tile SHALL be drawn only while frameCount[2]==0, where frameCount is a free-running 8-bit count of startOfFrame pulses.
REQ-018 drawingRequest SHALL be 1 when the pixel is inside a tile box that is SHOWN or visible-BLINK; the lowest index SHALL win on any overlap.
REQ-019 drawingRequest, digitValue, offsetX and offsetY SHALL be registered with exactly 1 cycle latency from pixelX/pixelY; outputs not qualified by drawingRequest SHALL be 0 when drawingRequest=0.
REQ-020 allCleared SHALL be 1 in PLAY when every tile is CLEARED, and 0 otherwise.
REQ-021 loading SHALL be 1 exactly while the FSM is in LOAD.
REQ-022 When newRound and singleHit occur in the same cycle, newRound SHALL win and no hitValid SHALL be generated.
REQ-023 When startOfFrame and a hit occur in the same cycle, the hit tile's counter SHALL load BLINK_FRAMES and SHALL NOT decrement that cycle.

Reset
REQ-024 On reset assertion, without waiting for clk: FSM=IDLE; all tiles EMPTY with value 0; LFSR=LFSR_SEED; frameCount=0; all outputs 0.
REQ-025 On reset release, operation SHALL resume on the next rising clk; no tile SHALL be drawn until a LOAD completes.

Verification
REQ-026 Reset, then newRound, default parameters -> loading=1 for exactly 12 cycles; then PLAY; all 12 tile values are 0..9 and match a reference LFSR model seeded 16'hACE1.
REQ-027 PLAY, pixel (150,150) -> next cycle drawingRequest=1, offsets 0/0, digitValue equals tile 0; pixel (166,150) -> drawingRequest=0.
REQ-028 singleHit while drawing tile 5 -> hitValid pulses once with hitIndex=5; a second singleHit on tile 5 -> no pulse; after 30 startOfFrame pulses tile 5 is CLEARED and never drawn.
REQ-029 Hit all 12 tiles and run 30 frames -> allCleared=1; newRound -> allCleared=0 and LOAD restarts.
REQ-030 newRound with singleHit in the same cycle -> no hitValid; reset asserted mid-LOAD -> all outputs 0 immediately and FSM=IDLE.

Source files
------------

// File: rtl/number_grid_controller.sv
// Grid of ROWS x COLS random-digit tiles: LFSR-seeded load sequence, per-pixel tile
// rendering with one cycle of latency, and hit/blink/clear bookkeeping per tile.
module number_grid_controller #(
    parameter int          ROWS         = 3,
    parameter int          COLS         = 4,
    parameter int          X0           = 150,
    parameter int          Y0           = 150,
    parameter int          DX           = 50,
    parameter int          DY           = 50,
    parameter int          TILE_W       = 16,
    parameter int          TILE_H       = 32,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        newRound,
    input  logic        singleHit,
    output logic        drawingRequest,
    output logic [3:0]  digitValue,
    output logic [4:0]  offsetX,
    output logic [5:0]  offsetY,
    output logic        hitValid,
    output logic [3:0]  hitIndex,
    output logic [3:0]  hitValue,
    output logic        allCleared,
    output logic        loading
);

    localparam int N  = ROWS * COLS;
    localparam int CW = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;
    typedef enum logic [1:0] {T_EMPTY, T_SHOWN, T_BLINK, T_CLEARED} tile_t;

    function automatic logic [10:0] tile_left(input int k);
        return 11'(X0 + (k % COLS) * DX);
    endfunction

    function automatic logic [10:0] tile_top(input int k);
        return 11'(Y0 + (k / COLS) * DY);
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      load_idx_q, load_idx_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    tile_t           tile_st_q [N];
    tile_t           tile_st_d [N];
    logic [3:0]      tile_val_q [N];
    logic [3:0]      tile_val_d [N];
    logic [CW-1:0]   blink_cnt_q [N];
    logic [CW-1:0]   blink_cnt_d [N];

    logic            draw_q, draw_d;
    logic [3:0]      draw_idx_q, draw_idx_d;
    logic [3:0]      digit_q, digit_d;
    logic [4:0]      off_x_q, off_x_d;
    logic [5:0]      off_y_q, off_y_d;
    logic            hit_valid_q, hit_valid_d;
    logic [3:0]      hit_index_q, hit_index_d;
    logic [3:0]      hit_value_q, hit_value_d;

    logic            hit;
    logic            all_clr;
    logic [3:0]      lfsr_digit;

    assign lfsr_digit = (lfsr_q[3:0] >= 4'd10) ? (lfsr_q[3:0] - 4'd10) : lfsr_q[3:0];

    always_comb begin
        state_d     = state_q;
        load_idx_d  = load_idx_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        frame_cnt_d = startOfFrame ? (frame_cnt_q + 8'd1) : frame_cnt_q;
        tile_st_d   = tile_st_q;
        tile_val_d  = tile_val_q;
        blink_cnt_d = blink_cnt_q;
        hit_valid_d = 1'b0;
        hit_index_d = 4'd0;
        hit_value_d = 4'd0;
        hit         = 1'b0;

        for (int k = 0; k < N; k++) begin
            if (tile_st_q[k] == T_BLINK && startOfFrame) begin
                if (blink_cnt_q[k] <= CW'(1)) begin
                    tile_st_d[k]   = T_CLEARED;
                    blink_cnt_d[k] = '0;
                end else begin
                    blink_cnt_d[k] = blink_cnt_q[k] - CW'(1);
                end
            end
        end

        case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                tile_st_d[load_idx_q]   = T_SHOWN;
                tile_val_d[load_idx_q]  = lfsr_digit;
                blink_cnt_d[load_idx_q] = '0;
                if (load_idx_q == 4'(N - 1)) begin
                    state_d    = S_PLAY;
                    load_idx_d = 4'd0;
                end else begin
                    load_idx_d = load_idx_q + 4'd1;
                end
            end
            S_PLAY: hit = singleHit && draw_q && (tile_st_q[draw_idx_q] == T_SHOWN);
            default: state_d = S_IDLE;
        endcase

        // A hit reloads the counter after any same-frame decrement, so it never loses a frame.
        if (hit && !newRound) begin
            tile_st_d[draw_idx_q]   = T_BLINK;
            blink_cnt_d[draw_idx_q] = CW'(BLINK_FRAMES);
            hit_valid_d             = 1'b1;
            hit_index_d             = draw_idx_q;
            hit_value_d             = tile_val_q[draw_idx_q];
        end

        if (newRound) begin
            state_d    = S_LOAD;
            load_idx_d = 4'd0;
            for (int k = 0; k < N; k++) begin
                tile_st_d[k]   = T_EMPTY;
                tile_val_d[k]  = 4'd0;
                blink_cnt_d[k] = '0;
            end
        end
    end

    // Scan from the highest index down so the lowest overlapping tile wins.
    always_comb begin
        draw_d     = 1'b0;
        draw_idx_d = 4'd0;
        digit_d    = 4'd0;
        off_x_d    = 5'd0;
        off_y_d    = 6'd0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pixelX >= tile_left(k) && pixelX < tile_left(k) + 11'(TILE_W) &&
                pixelY >= tile_top(k)  && pixelY < tile_top(k) + 11'(TILE_H) &&
                (tile_st_q[k] == T_SHOWN || (tile_st_q[k] == T_BLINK && !frame_cnt_q[2]))) begin
                draw_d     = 1'b1;
                draw_idx_d = 4'(k);
                digit_d    = tile_val_q[k];
                off_x_d    = 5'(pixelX - tile_left(k));
                off_y_d    = 6'(pixelY - tile_top(k));
            end
        end
    end

    always_comb begin
        all_clr = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (tile_st_q[k] != T_CLEARED) all_clr = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            load_idx_q  <= 4'd0;
            lfsr_q      <= LFSR_SEED;
            frame_cnt_q <= 8'd0;
            for (int k = 0; k < N; k++) begin
                tile_st_q[k]   <= T_EMPTY;
                tile_val_q[k]  <= 4'd0;
                blink_cnt_q[k] <= '0;
            end
            draw_q      <= 1'b0;
            draw_idx_q  <= 4'd0;
            digit_q     <= 4'd0;
            off_x_q     <= 5'd0;
            off_y_q     <= 6'd0;
            hit_valid_q <= 1'b0;
            hit_index_q <= 4'd0;
            hit_value_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            load_idx_q  <= load_idx_d;
            lfsr_q      <= lfsr_d;
            frame_cnt_q <= frame_cnt_d;
            tile_st_q   <= tile_st_d;
            tile_val_q  <= tile_val_d;
            blink_cnt_q <= blink_cnt_d;
            draw_q      <= draw_d;
            draw_idx_q  <= draw_idx_d;
            digit_q     <= digit_d;
            off_x_q     <= off_x_d;
            off_y_q     <= off_y_d;
            hit_valid_q <= hit_valid_d;
            hit_index_q <= hit_index_d;
            hit_value_q <= hit_value_d;
        end
    end

    assign drawingRequest = draw_q;
    assign digitValue     = digit_q;
    assign offsetX        = off_x_q;
    assign offsetY        = off_y_q;
    assign hitValid       = hit_valid_q;
    assign hitIndex       = hit_index_q;
    assign hitValue       = hit_value_q;
    assign allCleared     = (state_q == S_PLAY) && all_clr;
    assign loading        = (state_q == S_LOAD);

endmodule

// File: tb/tb_number_grid_controller.sv
// Directed bench for number_grid_controller: vector table for tile geometry plus
// hand sequences for load, hit, blink timing, round restart and reset.
module tb_number_grid_controller;

    localparam int N    = 12;
    localparam int COLS = 4;
    localparam int X0   = 150;
    localparam int Y0   = 150;
    localparam int DX   = 50;
    localparam int DY   = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic        newRound = 1'b0;
    logic        singleHit = 1'b0;
    logic        drawingRequest;
    logic [3:0]  digitValue;
    logic [4:0]  offsetX;
    logic [5:0]  offsetY;
    logic        hitValid;
    logic [3:0]  hitIndex;
    logic [3:0]  hitValue;
    logic        allCleared;
    logic        loading;

    number_grid_controller dut (
        .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .newRound(newRound), .singleHit(singleHit),
        .drawingRequest(drawingRequest), .digitValue(digitValue),
        .offsetX(offsetX), .offsetY(offsetY), .hitValid(hitValid),
        .hitIndex(hitIndex), .hitValue(hitValue), .allCleared(allCleared),
        .loading(loading)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, stepping every cycle out of reset.
    logic [15:0] m;
    always @(posedge clk or posedge reset) begin
        if (reset) m <= 16'hACE1;
        else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    typedef struct {
        int px;
        int py;
        int draw;
        int tile;
        int ox;
        int oy;
    } vec_t;

    vec_t vt [12];
    int   exp_val [N];
    int   fc;
    int   n_checks;
    int   n_errors;
    int   nl;
    int   ac0;

    function automatic int conv(input logic [3:0] n);
        return (n >= 4'd10) ? int'(n) - 10 : int'(n);
    endfunction

    function automatic int out_vec();
        return int'({drawingRequest, digitValue, offsetX, offsetY, hitValid,
                     hitIndex, hitValue, allCleared, loading});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_pix(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        fc++;
        @(negedge clk);
    endtask

    task automatic do_load(output int n, output int ac_first);
        newRound = 1'b1;
        @(negedge clk);
        newRound = 1'b0;
        ac_first = int'(allCleared);
        n = 0;
        while (loading && n < 40) begin
            if (n < N) exp_val[n] = conv(m[3:0]);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic scan(input string tag);
        for (int k = 0; k < N; k++) begin
            set_pix(X0 + (k % COLS) * DX + 3, Y0 + (k / COLS) * DY + 7);
            @(negedge clk);
            chk($sformatf("%s_draw%0d", tag, k), int'(drawingRequest), 1);
            chk($sformatf("%s_digit%0d", tag, k), int'(digitValue), exp_val[k]);
            chk($sformatf("%s_offx%0d", tag, k), int'(offsetX), 3);
            chk($sformatf("%s_offy%0d", tag, k), int'(offsetY), 7);
        end
    endtask

    task automatic hit_tile(input int k, input logic with_sof);
        set_pix(X0 + (k % COLS) * DX + 1, Y0 + (k / COLS) * DY + 1);
        @(negedge clk);
        singleHit    = 1'b1;
        startOfFrame = with_sof;
        @(negedge clk);
        singleHit    = 1'b0;
        startOfFrame = 1'b0;
        if (with_sof) fc++;
        chk($sformatf("hit%0d_valid", k), int'(hitValid), 1);
        chk($sformatf("hit%0d_index", k), int'(hitIndex), k);
        chk($sformatf("hit%0d_value", k), int'(hitValue), exp_val[k]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ed;
        n_checks = 0;
        n_errors = 0;
        fc = 0;

        vt[0]  = '{150, 150, 1,  0,  0,  0};
        vt[1]  = '{166, 150, 0, -1,  0,  0};
        vt[2]  = '{165, 181, 1,  0, 15, 31};
        vt[3]  = '{165, 182, 0, -1,  0,  0};
        vt[4]  = '{149, 150, 0, -1,  0,  0};
        vt[5]  = '{200, 150, 1,  1,  0,  0};
        vt[6]  = '{260, 210, 1,  6, 10, 10};
        vt[7]  = '{315, 281, 1, 11, 15, 31};
        vt[8]  = '{316, 250, 0, -1,  0,  0};
        vt[9]  = '{  0,   0, 0, -1,  0,  0};
        vt[10] = '{205, 203, 1,  5,  5,  3};
        vt[11] = '{174, 180, 0, -1,  0,  0};

        #3;
        chk("reset_outputs", out_vec(), 0);
        @(negedge clk);
        reset = 1'b0;

        do_load(nl, ac0);
        chk("load1_cycles", nl, 12);
        chk("load1_allcleared", ac0, 0);
        chk("play_allcleared", int'(allCleared), 0);
        chk("play_loading", int'(loading), 0);
        scan("r1");

        for (int i = 0; i < 12; i++) begin
            set_pix(vt[i].px, vt[i].py);
            @(negedge clk);
            ed = (vt[i].tile >= 0) ? exp_val[vt[i].tile] : 0;
            chk($sformatf("vec%0d_draw", i), int'(drawingRequest), vt[i].draw);
            chk($sformatf("vec%0d_digit", i), int'(digitValue), ed);
            chk($sformatf("vec%0d_offx", i), int'(offsetX), vt[i].ox);
            chk($sformatf("vec%0d_offy", i), int'(offsetY), vt[i].oy);
        end

        for (int i = 0; i < 3; i++) sof_pulse();

        set_pix(205, 203);
        @(negedge clk);
        chk("t5_draw_before_hit", int'(drawingRequest), 1);
        singleHit = 1'b1;
        @(negedge clk);
        singleHit = 1'b0;
        chk("t5_hit_valid", int'(hitValid), 1);
        chk("t5_hit_index", int'(hitIndex), 5);
        chk("t5_hit_value", int'(hitValue), exp_val[5]);
        @(negedge clk);
        chk("t5_hit_single_pulse", int'(hitValid), 0);
        singleHit = 1'b1;
        @(negedge clk);
        singleHit = 1'b0;
        chk("t5_rehit_none_a", int'(hitValid), 0);
        @(negedge clk);
        chk("t5_rehit_none_b", int'(hitValid), 0);
        for (int i = 1; i <= 34; i++) begin
            sof_pulse();
            chk($sformatf("t5_blink_f%0d", i), int'(drawingRequest),
                (i < 30 && (fc & 4) == 0) ? 1 : 0);
        end

        set_pix(205, 203);
        @(negedge clk);
        singleHit = 1'b1;
        @(negedge clk);
        singleHit = 1'b0;
        chk("hit_cleared_tile", int'(hitValid), 0);
        set_pix(0, 0);
        @(negedge clk);
        singleHit = 1'b1;
        @(negedge clk);
        singleHit = 1'b0;
        chk("hit_no_tile", int'(hitValid), 0);

        // Align so tile 0 is in a visible blink phase after its 29th decrement.
        for (int g = 0; g < 8 && ((fc + 30) & 4) != 0; g++) sof_pulse();
        hit_tile(0, 1'b1);
        for (int k = 1; k < N; k++) begin
            if (k != 5) hit_tile(k, 1'b0);
        end
        set_pix(151, 151);
        for (int i = 1; i <= 29; i++) sof_pulse();
        chk("t0_sof_hit_still_blink", int'(drawingRequest), ((fc & 4) == 0) ? 1 : 0);
        chk("allcleared_f29", int'(allCleared), 0);
        sof_pulse();
        chk("allcleared_f30", int'(allCleared), 1);
        chk("t0_cleared_hidden", int'(drawingRequest), 0);

        do_load(nl, ac0);
        chk("load2_allcleared", ac0, 0);
        chk("load2_cycles", nl, 12);
        scan("r2");

        set_pix(X0 + 2 * DX + 1, Y0 + 1);
        @(negedge clk);
        newRound  = 1'b1;
        singleHit = 1'b1;
        @(negedge clk);
        newRound  = 1'b0;
        singleHit = 1'b0;
        chk("nr_hit_no_valid_a", int'(hitValid), 0);
        chk("nr_hit_loading", int'(loading), 1);
        @(negedge clk);
        chk("nr_hit_no_valid_b", int'(hitValid), 0);
        @(negedge clk);
        do_load(nl, ac0);
        chk("load3_midload_cycles", nl, 12);
        scan("r3");

        set_pix(151, 151);
        newRound = 1'b1;
        @(negedge clk);
        newRound = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("midload_loading", int'(loading), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_load_outputs", out_vec(), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_nodraw%0d", i), int'(drawingRequest), 0);
        end
        do_load(nl, ac0);
        chk("load4_cycles", nl, 12);
        scan("r4");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
